spi_master: RTL and testbench

- Byte-frame SPI master: drives sck, ss and mosi, and samples miso.
- It is the initiator-side counterpart of the bitrev-style SPI slave peripherals.
- Takes a LEN-bit word on a valid/ready request port and shifts it out MSB-first while shifting miso in.
- Returns the captured LEN-bit word on a valid/ready response port.
- Sits between a bus-side controller (or testbench driver) and an SPI slave such as the bit-reverse peripheral.

---
 rtl/spi_master.sv | 207 ++++++++++++++++++++
 tb/tb_spi_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// ============================================================================
// Module  : spi_master
// Purpose : Byte-frame SPI master. Accepts a LEN-bit word on a valid/ready
//           request port and shifts it out on mosi, MSB first. At the same
//           time it shifts miso in, and returns the captured word on a
//           valid/ready response port. sck idles low. The slave samples mosi
//           on the rising edge of sck. The master samples miso in the last
//           system-clock cycle of each sck high phase. ss is active-high.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LEN  : bits per frame (number of sck rising edges), >= 1
//   DIV  : sck half-period in clock cycles, >= 1
// Ports
//   clock      in   system clock, rising-edge active
//   reset      in   asynchronous active-high reset
//   req_valid  in   request word present
//   req_ready  out  master can accept a request (IDLE only)
//   req_data   in   [LEN] word to transmit, MSB first
//   resp_valid out  received word available
//   resp_ready in   consumer accepts the response
//   resp_data  out  [LEN] received word, first sampled bit at MSB
//   sck        out  SPI clock, idle low
//   ss         out  slave select, active-high
//   mosi       out  master-out data
//   miso       in   slave-out data
// ============================================================================
`default_nettype none

module spi_master #(
  parameter int LEN = 16,
  parameter int DIV = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [LEN-1:0] req_data,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [LEN-1:0] resp_data,
  output logic           sck,
  output logic           ss,
  output logic           mosi,
  input  logic           miso
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t           state_q;
  logic [LEN-1:0]   tx_q;
  logic [LEN-1:0]   rx_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic             sck_q;
  logic             ss_q;
  logic             mosi_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic [LEN-1:0]   resp_data_q;
  // The first SETUP cycle only raises ss and presents the MSB on mosi.
  // The DIV-cycle setup count starts after that cycle.
  logic             start_q;
  // Set once the final bit has been sampled. The closing low phase then
  // leads into HOLD instead of producing another rising edge.
  logic             last_q;

  logic [LEN-1:0]   tx_shift_d;
  logic [LEN-1:0]   rx_shift_d;
  logic             div_end_d;

  assign tx_shift_d = tx_q << 1;
  assign div_end_d  = (div_cnt_q == C_DIV_LAST);

  // Receive shift: a one-bit frame has nothing to shift, so it takes miso directly.
  generate
    if (LEN == 1) begin : g_rx_single
      assign rx_shift_d = miso;
    end else begin : g_rx_multi
      assign rx_shift_d = {rx_q[LEN-2:0], miso};
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      sck_q        <= 1'b0;
      ss_q         <= 1'b0;
      mosi_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      start_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            tx_q        <= req_data;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            start_q     <= 1'b1;
            last_q      <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (start_q) begin
            start_q <= 1'b0;
            ss_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= tx_q[LEN-1];
          end else if (div_end_d) begin
            div_cnt_q <= '0;
            sck_q     <= 1'b1;
            state_q   <= S_XFER;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end

        S_XFER: begin
          if (!div_end_d) begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end else begin
            div_cnt_q <= '0;
            if (sck_q) begin
              // End of high phase: sample miso, drop sck, and advance mosi
              // on this falling-edge cycle so it is stable for the next high phase.
              sck_q <= 1'b0;
              rx_q  <= rx_shift_d;
              if (bit_cnt_q == C_BIT_LAST) begin
                mosi_q <= 1'b0;
                last_q <= 1'b1;
              end else begin
                tx_q      <= tx_shift_d;
              mosi_q    <= tx_shift_d[LEN-1];
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else if (last_q) begin
              state_q <= S_HOLD;
            end else begin
              sck_q <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (div_end_d) begin
            div_cnt_q    <= '0;
            ss_q         <= 1'b0;
            resp_data_q  <= rx_q;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          sck_q        <= 1'b0;
          ss_q         <= 1'b0;
          mosi_q       <= 1'b0;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign sck        = sck_q;
  assign ss         = ss_q;
  assign mosi       = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module  : tb_spi_master
// Purpose : Directed self-checking bench for spi_master. It instantiates
//           three copies: LEN=16/DIV=2 (main), LEN=8/DIV=1, and LEN=8/DIV=5.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        resp_ready;
  logic [15:0] req_data;
  logic [1:0]  sel;
  logic [1:0]  miso_mode;

  int checks = 0;
  int errors = 0;

  // Main DUT, LEN=16 DIV=2
  logic        rv0, rr0, r0_ready, p0_valid, sck0, ss0, mosi0, miso0;
  logic [15:0] p0_data;
  // Sweep DUTs, LEN=8
  logic        rv1, rr1, r1_ready, p1_valid, sck1, ss1, mosi1;
  logic [7:0]  p1_data;
  logic        rv2, rr2, r2_ready, p2_valid, sck2, ss2, mosi2;
  logic [7:0]  p2_data;

  // Behavioural slave: returns SLV word MSB first and advances on each sck fall.
  logic [15:0] slv_word = 16'h5A3C;
  int          slv_cnt  = 0;
  logic        slv_miso;

  always @(negedge sck0 or negedge ss0) begin
    if (!ss0) slv_cnt <= 0;
    else      slv_cnt <= slv_cnt + 1;
  end
  assign slv_miso = (slv_cnt < 16) ? slv_word[15 - slv_cnt] : 1'b0;

  always_comb begin
    case (miso_mode)
      2'd0:    miso0 = mosi0;
      2'd1:    miso0 = 1'b1;
      2'd2:    miso0 = 1'b0;
      default: miso0 = slv_miso;
    endcase
  end

  assign rv0 = req_valid  && (sel == 2'd0);
  assign rr0 = resp_ready && (sel == 2'd0);
  assign rv1 = req_valid  && (sel == 2'd1);
  assign rr1 = resp_ready && (sel == 2'd1);
  assign rv2 = req_valid  && (sel == 2'd2);
  assign rr2 = resp_ready && (sel == 2'd2);

  spi_master #(.LEN(16), .DIV(2)) u_dut0 (
    .clock(clk), .reset(reset), .req_valid(rv0), .req_ready(r0_ready),
    .req_data(req_data), .resp_valid(p0_valid), .resp_ready(rr0),
    .resp_data(p0_data), .sck(sck0), .ss(ss0), .mosi(mosi0), .miso(miso0)
  );

  spi_master #(.LEN(8), .DIV(1)) u_dut1 (
    .clock(clk), .reset(reset), .req_valid(rv1), .req_ready(r1_ready),
    .req_data(req_data[7:0]), .resp_valid(p1_valid), .resp_ready(rr1),
    .resp_data(p1_data), .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(mosi1)
  );

  spi_master #(.LEN(8), .DIV(5)) u_dut2 (
    .clock(clk), .reset(reset), .req_valid(rv2), .req_ready(r2_ready),
    .req_data(req_data[7:0]), .resp_valid(p2_valid), .resp_ready(rr2),
    .resp_data(p2_data), .sck(sck2), .ss(ss2), .mosi(mosi2), .miso(mosi2)
  );

  // View of the currently selected DUT
  logic        v_sck, v_ss, v_mosi, v_req_ready, v_resp_valid;
  logic [15:0] v_resp_data;
  always_comb begin
    case (sel)
      2'd1: begin
        v_sck = sck1; v_ss = ss1; v_mosi = mosi1; v_req_ready = r1_ready;
        v_resp_valid = p1_valid; v_resp_data = {8'h00, p1_data};
      end
      2'd2: begin
        v_sck = sck2; v_ss = ss2; v_mosi = mosi2; v_req_ready = r2_ready;
        v_resp_valid = p2_valid; v_resp_data = {8'h00, p2_data};
      end
      default: begin
        v_sck = sck0; v_ss = ss0; v_mosi = mosi0; v_req_ready = r0_ready;
        v_resp_valid = p0_valid; v_resp_data = p0_data;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for resp_valid on the selected DUT.
  task automatic wait_resp(output logic got);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (v_resp_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Consume the pending response and confirm the handshake returns to IDLE.
  task automatic consume(input string tag);
    @(negedge clk) resp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_rv_drop"}, 32'(v_resp_valid), 32'd0);
    check({tag, "_rdy_back"}, 32'(v_req_ready), 32'd1);
    check({tag, "_ss_idle"}, 32'(v_ss), 32'd0);
    @(negedge clk) resp_ready = 1'b0;
  endtask

  // Run one frame on the selected DUT and measure its shape.
  task automatic run_frame(input logic [15:0] data, input int len, input int div,
                           input int exp_lat, input logic [15:0] exp_rsp,
                           input string tag);
    int lat = -1, rises = 0, ss_rise = -1, ss_fall = -1;
    int first_rise = -1, last_rise = 0, last_fall = 0;
    int bad_width = 0, sck_wo_ss = 0, rdy_busy = 0;
    logic prev_sck = 1'b0, prev_ss = 1'b0;
    logic [15:0] mosi_bits = 16'h0000;
    logic ok_setup, ok_hold;
    for (int i = 0; i < 50 && !v_req_ready; i++) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = ~data;  // must not affect the frame in flight
    for (int cyc = 1; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      if (v_ss && !prev_ss) ss_rise = cyc;
      if (!v_ss && prev_ss) ss_fall = cyc;
      if (v_sck && !v_ss) sck_wo_ss++;
      if (v_req_ready) rdy_busy++;
      if (v_sck && !prev_sck) begin
        rises++;
        if (first_rise < 0) first_rise = cyc;
        else if (cyc - last_fall != div) bad_width++;
        mosi_bits = {mosi_bits[14:0], v_mosi};
        last_rise = cyc;
      end
      if (!v_sck && prev_sck) begin
        if (cyc - last_rise != div) bad_width++;
        last_fall = cyc;
      end
      prev_sck = v_sck;
      prev_ss  = v_ss;
      if (v_resp_valid) begin
        lat = cyc;
        break;
      end
    end
    ok_setup = (ss_rise >= 0) && (first_rise - ss_rise >= div);
    ok_hold  = (ss_fall >= 0) && (ss_fall - last_fall >= div);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_resp_data"}, 32'(v_resp_data), 32'(exp_rsp));
    check({tag, "_rises"}, 32'(rises), 32'(len));
    check({tag, "_mosi_bits"}, 32'(mosi_bits), 32'(data));
    check({tag, "_ss_setup"}, 32'(ok_setup), 32'd1);
    check({tag, "_ss_hold"}, 32'(ok_hold), 32'd1);
    check({tag, "_phase_width"}, 32'(bad_width), 32'd0);
    check({tag, "_sck_without_ss"}, 32'(sck_wo_ss), 32'd0);
    check({tag, "_ready_busy"}, 32'(rdy_busy), 32'd0);
  endtask

  initial begin
    int   bad;
    logic got;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_data = 16'h0000;
    sel = 2'd0; miso_mode = 2'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_sck", 32'(sck0), 32'd0);
    check("rst_ss", 32'(ss0), 32'd0);
    check("rst_mosi", 32'(mosi0), 32'd0);
    check("rst_req_ready", 32'(r0_ready), 32'd1);
    check("rst_resp_valid", 32'(p0_valid), 32'd0);
    check("rst_resp_data", 32'(p0_data), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Idle with no requests
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (sck0 !== 1'b0 || ss0 !== 1'b0 || mosi0 !== 1'b0 ||
          r0_ready !== 1'b1 || p0_valid !== 1'b0) bad++;
    end
    check("idle_50", 32'(bad), 32'd0);

    // Loopback: latency (2*16+2)*2+1 = 69
    run_frame(16'hA55A, 16, 2, 69, 16'hA55A, "loop_a55a");
    consume("loop_a55a");

    // Constant miso
    miso_mode = 2'd1;
    run_frame(16'h0000, 16, 2, 69, 16'hFFFF, "miso1");
    consume("miso1");
    miso_mode = 2'd2;
    run_frame(16'hFFFF, 16, 2, 69, 16'h0000, "miso0");
    consume("miso0");

    // Response backpressure with a second request held
    miso_mode = 2'd0;
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 16'h1234;
    @(posedge clk); #1;
    @(negedge clk) req_data = 16'h5678;
    wait_resp(got);
    check("bp_first_resp", 32'(got), 32'd1);
    check("bp_first_data", 32'(p0_data), 32'h1234);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (p0_data !== 16'h1234 || r0_ready !== 1'b0 || sck0 !== 1'b0 ||
          p0_valid !== 1'b1) bad++;
    end
    check("bp_stall_20", 32'(bad), 32'd0);
    @(negedge clk) resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rv_drop", 32'(p0_valid), 32'd0);
    check("bp_ready_next", 32'(r0_ready), 32'd1);
    @(negedge clk) resp_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_second_accepted", 32'(r0_ready), 32'd0);
    @(negedge clk) req_valid = 1'b0;
    wait_resp(got);
    check("bp_second_resp", 32'(got), 32'd1);
    check("bp_second_data", 32'(p0_data), 32'h5678);
    consume("bp_second");

    // Behavioural slave returns 0x5A3C (second byte 0x3C)
    miso_mode = 2'd3;
    run_frame(16'h81FF, 16, 2, 69, 16'h5A3C, "slave");
    check("slave_low_byte", 32'(p0_data[7:0]), 32'h3C);
    consume("slave");
    miso_mode = 2'd0;

    // Reset mid-frame
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = 16'hF0F0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_in_frame_ss", 32'(ss0), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_ss", 32'(ss0), 32'd0);
    check("midrst_sck", 32'(sck0), 32'd0);
    @(negedge clk) reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (p0_valid !== 1'b0 || r0_ready !== 1'b1 || ss0 !== 1'b0) bad++;
    end
    check("midrst_quiet", 32'(bad), 32'd0);

    // Parameter sweep LEN=8: DIV=1 -> 19 cycles, DIV=5 -> 91 cycles
    sel = 2'd1;
    run_frame(16'h00C3, 8, 1, 19, 16'h00C3, "div1");
    consume("div1");
    sel = 2'd2;
    run_frame(16'h00C3, 8, 5, 91, 16'h00C3, "div5");
    consume("div5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
